// File: rtl/mlp_pkg.sv
// Shared definitions for the serial MLP inference controller.
//   - default geometry (W, N, P, SETTLE) and the hidden raw-score width HRAW_W
//   - sequencer state enum
//   - sext: sign-extend a default-width weight/bias to HRAW_W
package mlp_pkg;

    parameter int unsigned W_DEF      = 8;
    parameter int unsigned N_DEF      = 8;
    parameter int unsigned P_DEF      = 9;
    parameter int unsigned SETTLE_DEF = 2;
    parameter int unsigned HRAW_W     = W_DEF + 5;

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StWait,
        StOut
    } state_e;

    function automatic logic [HRAW_W-1:0] sext(input logic [W_DEF-1:0] v);
        return {{(HRAW_W - W_DEF){v[W_DEF-1]}}, v};
    endfunction

endpackage

// File: rtl/mlp_serial_mac.sv
// Serial multiply-free accumulator for the hidden layer.
// One (n,p) term per cycle while step is high; binary pixels turn the product
// into a select. On the last pixel of a neuron the finished sum is presented
// on wr_data with wr_en, and the accumulator is reloaded with the next bias.
// Ports:
//   clk, rst        clock, async active-high reset
//   load_first      load bias of neuron 0 (accept cycle)
//   step            accumulate term (n,p) this cycle
//   pix, n, p       captured pixels and current indices
//   w_h_bus,b_h_bus live hidden weights / biases
//   wr_en, wr_data  lane write strobe and value for neuron n
module mlp_serial_mac
    import mlp_pkg::*;
#(
    parameter int unsigned W  = W_DEF,
    parameter int unsigned N  = N_DEF,
    parameter int unsigned P  = P_DEF,
    parameter int unsigned NW = 3,
    parameter int unsigned PW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_first,
    input  logic             step,
    input  logic [P-1:0]     pix,
    input  logic [NW-1:0]    n,
    input  logic [PW-1:0]    p,
    input  logic [N*P*W-1:0] w_h_bus,
    input  logic [N*W-1:0]   b_h_bus,
    output logic             wr_en,
    output logic [W+4:0]     wr_data
);

    localparam int unsigned HW = W + 5;

    localparam logic [PW-1:0] PLast = PW'(P - 1);
    localparam logic [NW-1:0] NLast = NW'(N - 1);

    logic [HW-1:0] acc_q, acc_d;
    logic [HW-1:0] term, sum;
    logic [W-1:0]  w_sel, b_first, b_next;
    logic          last_p, last_n;
    int            nxt;

    always_comb begin
        last_p  = (p == PLast);
        last_n  = (n == NLast);
        w_sel   = w_h_bus[(int'(n) * P + int'(p)) * W +: W];
        term    = pix[p] ? {{(HW - W){w_sel[W-1]}}, w_sel} : '0;
        sum     = acc_q + term;
        // Next-bias lane is don't-care after the last neuron; keep the index in range.
        nxt     = last_n ? 0 : int'(n) + 1;
        b_first = b_h_bus[W-1:0];
        b_next  = b_h_bus[nxt * W +: W];

        acc_d = acc_q;
        if (load_first) begin
            acc_d = {{(HW - W){b_first[W-1]}}, b_first};
        end else if (step) begin
            acc_d = last_p ? {{(HW - W){b_next[W-1]}}, b_next} : sum;
        end

        wr_en   = step & last_p;
        wr_data = sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/mlp_infer_ctrl.sv
// Sequencer for one O/X inference through the two-layer MLP.
// Accepts a 3x3 binary pixel vector, computes N hidden raw scores serially via
// mlp_serial_mac, drives them on h_raw_bus, waits SETTLE+1 edges for the
// output-score stage, then returns the sampled y_score and its class bit.
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready/in_pix pixel vector handshake
//   w_h_bus, b_h_bus         hidden weights / biases (held by source)
//   h_raw_bus                hidden raw scores to output stage
//   y_score                  score from output stage
//   out_valid/out_ready      result handshake; out_score, out_class
//   busy                     not idle
module mlp_infer_ctrl
    import mlp_pkg::*;
#(
    parameter int unsigned W      = W_DEF,
    parameter int unsigned N      = N_DEF,
    parameter int unsigned P      = P_DEF,
    parameter int unsigned SETTLE = SETTLE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [P-1:0]         in_pix,
    input  logic [N*P*W-1:0]     w_h_bus,
    input  logic [N*W-1:0]       b_h_bus,
    output logic [N*(W+5)-1:0]   h_raw_bus,
    input  logic [W+4:0]         y_score,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W+4:0]         out_score,
    output logic                 out_class,
    output logic                 busy
);

    localparam int unsigned HW = W + 5;
    localparam int unsigned NW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    localparam logic [PW-1:0] PLast = PW'(P - 1);
    localparam logic [NW-1:0] NLast = NW'(N - 1);
    localparam logic [CW-1:0] CLast = CW'(SETTLE);

    state_e          state_q, state_d;
    logic [NW-1:0]   n_q, n_d;
    logic [PW-1:0]   p_q, p_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [P-1:0]    pix_q, pix_d;
    logic [N*HW-1:0] h_raw_q;
    logic [HW-1:0]   score_q, score_d;
    logic            class_q, class_d;
    logic            load_first, step;
    logic            wr_en;
    logic [HW-1:0]   wr_data;

    mlp_serial_mac #(
        .W  (W),
        .N  (N),
        .P  (P),
        .NW (NW),
        .PW (PW)
    ) u_mac (
        .clk        (clk),
        .rst        (rst),
        .load_first (load_first),
        .step       (step),
        .pix        (pix_q),
        .n          (n_q),
        .p          (p_q),
        .w_h_bus    (w_h_bus),
        .b_h_bus    (b_h_bus),
        .wr_en      (wr_en),
        .wr_data    (wr_data)
    );

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        p_d        = p_q;
        cnt_d      = cnt_q;
        pix_d      = pix_q;
        score_d    = score_q;
        class_d    = class_q;
        load_first = 1'b0;
        step       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    load_first = 1'b1;
                    pix_d      = in_pix;
                    n_d        = '0;
                    p_d        = '0;
                    state_d    = StAcc;
                end
            end
            StAcc: begin
                step = 1'b1;
                if (p_q == PLast) begin
                    p_d = '0;
                    if (n_q == NLast) begin
                        n_d     = '0;
                        cnt_d   = '0;
                        state_d = StWait;
                    end else begin
                        n_d = n_q + 1'b1;
                    end
                end else begin
                    p_d = p_q + 1'b1;
                end
            end
            StWait: begin
                if (cnt_q == CLast) begin
                    score_d = y_score;
                    // Signed y_score > 0: non-negative and non-zero.
                    class_d = ~y_score[HW-1] & (|y_score);
                    state_d = StOut;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            n_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            pix_q   <= '0;
            h_raw_q <= '0;
            score_q <= '0;
            class_q <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            pix_q   <= pix_d;
            score_q <= score_d;
            class_q <= class_d;
            if (wr_en) begin
                h_raw_q[int'(n_q) * HW +: HW] <= wr_data;
            end
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StOut);
    assign out_score = score_q;
    assign out_class = class_q;
    assign h_raw_bus = h_raw_q;

endmodule

// File: tb/tb_mlp_infer_ctrl.sv
// Bench for mlp_infer_ctrl: behavioural output-score stage behind h_raw_bus,
// scoreboard queue filled at accept, monitor compares on each out_valid rise.
module tb_mlp_infer_ctrl;
    import mlp_pkg::*;

    localparam int W      = 8;
    localparam int N      = 8;
    localparam int P      = 9;
    localparam int SETTLE = 2;
    localparam int HW     = W + 5;
    localparam int LAT    = N * P + SETTLE + 1;
    localparam int PERIOD = LAT + 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [P-1:0]        in_pix;
    logic [N*P*W-1:0]    w_h_bus;
    logic [N*W-1:0]      b_h_bus;
    logic [N*HW-1:0]     h_raw_bus;
    logic [HW-1:0]       y_score;
    logic                out_valid;
    logic                out_ready;
    logic [HW-1:0]       out_score;
    logic                out_class;
    logic                busy;

    int wh[N][P];
    int bh[N];
    int wo[N];
    int bo;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    bit rand_rdy = 1'b0;

    typedef struct packed {
        logic [N*HW-1:0] hraw;
        logic [HW-1:0]   score;
        logic            cls;
        logic [31:0]     edge_k;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mlp_infer_ctrl #(
        .W      (W),
        .N      (N),
        .P      (P),
        .SETTLE (SETTLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pix    (in_pix),
        .w_h_bus   (w_h_bus),
        .b_h_bus   (b_h_bus),
        .h_raw_bus (h_raw_bus),
        .y_score   (y_score),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_score (out_score),
        .out_class (out_class),
        .busy      (busy)
    );

    always_comb begin
        w_h_bus = '0;
        b_h_bus = '0;
        for (int n = 0; n < N; n++) begin
            b_h_bus[n*W +: W] = W'(bh[n]);
            for (int p = 0; p < P; p++) w_h_bus[(n*P+p)*W +: W] = W'(wh[n][p]);
        end
    end

    // Output-score stage: step activation on hidden scores, then SETTLE registers.
    function automatic logic [HW-1:0] os_calc(input logic [N*HW-1:0] hb);
        int s;
        s = bo;
        for (int n = 0; n < N; n++) if ($signed(hb[n*HW +: HW]) > 0) s += wo[n];
        return HW'(s);
    endfunction

    logic [HW-1:0] os_s1, os_s2;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            os_s1 <= '0;
            os_s2 <= '0;
        end else begin
            os_s1 <= os_calc(h_raw_bus);
            os_s2 <= os_s1;
        end
    end
    assign y_score = os_s2;

    // Reference: plain integer dot products from the inputs.
    function automatic exp_t model(input logic [P-1:0] px, input int edge_k);
        exp_t e;
        int h, y;
        e = '0;
        y = bo;
        for (int n = 0; n < N; n++) begin
            h = bh[n];
            for (int p = 0; p < P; p++) if (px[p]) h += wh[n][p];
            e.hraw[n*HW +: HW] = HW'(h);
            if (h > 0) y += wo[n];
        end
        e.score  = HW'(y);
        e.cls    = (y > 0);
        e.edge_k = 32'(edge_k);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_uniform(input int w, input int b);
        for (int n = 0; n < N; n++) begin
            bh[n] = b;
            for (int p = 0; p < P; p++) wh[n][p] = w;
        end
    endtask

    int last_acc = -1;

    // Called at a negedge; offers px once in_ready, optionally loading uniform weights.
    task automatic send(input logic [P-1:0] px, input bit push, input bit keep,
                        input bit uni, input int uw, input int ub);
        int guard = 0;
        while (!in_ready && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            return;
        end
        if (uni) set_uniform(uw, ub);
        in_pix   = px;
        in_valid = 1'b1;
        last_acc = cyc + 1;
        if (push) q.push_back(model(px, cyc + 1));
        @(negedge clk);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        while (!(q.size() == 0 && in_ready && !out_valid) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) chk("done_timeout", 64'd0, 64'd1);
    endtask

    // Monitor
    initial begin
        exp_t e;
        logic prev_valid = 1'b0;
        logic [HW-1:0] held_score = '0;
        logic held_class = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid && !prev_valid) begin
                    if (q.size() == 0) begin
                        chk("unexpected_out_valid", 64'd1, 64'd0);
                    end else begin
                        e = q.pop_front();
                        chk("out_score", 64'(out_score), 64'(e.score));
                        chk("out_class", 64'(out_class), 64'(e.cls));
                        chk("latency", 64'(cyc - int'(e.edge_k)), 64'(LAT));
                        for (int n = 0; n < N; n++)
                            chk("h_raw_lane", 64'(h_raw_bus[n*HW +: HW]), 64'(e.hraw[n*HW +: HW]));
                    end
                    held_score = out_score;
                    held_class = out_class;
                end else if (out_valid && prev_valid) begin
                    chk("hold_score", 64'(out_score), 64'(held_score));
                    chk("hold_class", 64'(out_class), 64'(held_class));
                    chk("in_ready_while_out", 64'(in_ready), 64'd0);
                end
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_pix    = '0;
        out_ready = 1'b1;
        bo        = -4;
        for (int n = 0; n < N; n++) wo[n] = 1;
        set_uniform(0, 0);

        repeat (3) @(negedge clk);
        chk("rst_h_raw", 64'(h_raw_bus), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_score", 64'(out_score), 64'd0);
        chk("rst_out_class", 64'(out_class), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Basic X / O cases
        send(9'h1FF, 1'b1, 1'b0, 1'b1, 1, 0);
        wait_done();
        chk("x_lane0", 64'(h_raw_bus[0 +: HW]), 64'd9);
        chk("x_lane7", 64'(h_raw_bus[7*HW +: HW]), 64'd9);
        chk("x_score", 64'(out_score), 64'd4);
        chk("x_class", 64'(out_class), 64'd1);

        send(9'h1FF, 1'b1, 1'b0, 1'b1, -1, 0);
        wait_done();
        chk("o_lane3", 64'(h_raw_bus[3*HW +: HW]), 64'(sext(8'hF7)));
        chk("o_score", 64'(out_score), 64'h1FFC);
        chk("o_class", 64'(out_class), 64'd0);

        // Range extremes
        send(9'h1FF, 1'b1, 1'b0, 1'b1, -128, -128);
        wait_done();
        chk("neg_extreme", 64'(h_raw_bus[5*HW +: HW]), 64'h1B00);
        send(9'h1FF, 1'b1, 1'b0, 1'b1, 127, 127);
        wait_done();
        chk("pos_extreme", 64'(h_raw_bus[2*HW +: HW]), 64'h04F6);

        // Backpressure
        out_ready = 1'b0;
        send(9'h155, 1'b1, 1'b0, 1'b1, 1, 0);
        begin
            int guard = 0;
            while (!out_valid && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (!out_valid) chk("bp_out_valid_timeout", 64'd0, 64'd1);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle_next", 64'(in_ready), 64'd1);
        chk("bp_valid_drop", 64'(out_valid), 64'd0);
        send(9'h0F0, 1'b1, 1'b0, 1'b1, -1, 3);
        wait_done();

        // Reset mid-ACC
        send(9'h1FF, 1'b0, 1'b0, 1'b1, 1, 2);
        repeat (29) @(negedge clk);
        chk("busy_mid_acc", 64'(busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_h_raw", 64'(h_raw_bus), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        repeat (100) @(negedge clk);

        // Back-to-back, alternating X / O
        for (int i = 0; i < 6; i++) begin
            int prev;
            prev = last_acc;
            send(9'h1FF, 1'b1, 1'b1, 1'b1, (i % 2 == 0) ? 1 : -1, 0);
            if (i > 0) chk("b2b_period", 64'(last_acc - prev), 64'(PERIOD));
        end
        in_valid = 1'b0;
        wait_done();

        // Randomized vectors with random output backpressure
        rand_rdy = 1'b1;
        for (int t = 0; t < 10; t++) begin
            wait_done();
            bo = int'($urandom_range(0, 31)) - 16;
            for (int n = 0; n < N; n++) begin
                wo[n] = int'($urandom_range(0, 15)) - 8;
                bh[n] = int'($urandom_range(0, 255)) - 128;
                for (int p = 0; p < P; p++) wh[n][p] = int'($urandom_range(0, 255)) - 128;
            end
            send(P'($urandom_range(0, 511)), 1'b1, 1'b0, 1'b0, 0, 0);
        end
        wait_done();
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
